// File: rtl/trdb_pkg.sv
// Shared types for the trace-debug qualification tracker.
package trdb_pkg;

    localparam int TRDB_XLEN         = 32;
    localparam int TRDB_RESYNC_CNT_W = 16;

    // One staged retired instruction: address plus its filter decision.
    typedef struct packed {
        logic [TRDB_XLEN-1:0] iaddr;
        logic                 qual;
    } trdb_stage_t;

    typedef enum logic {ST_EMPTY, ST_STAGED} trdb_stage_state_e;

    typedef enum logic {TR_OFF, TR_ON} trdb_trace_state_e;

    // A qualified run continues past the emitted instruction only when both
    // the emitted instruction and its lookahead are qualified.
    function automatic trdb_trace_state_e trdb_next_trace(input logic s_qual, input logic l_qual);
        return (s_qual && l_qual) ? TR_ON : TR_OFF;
    endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// Counts qualified emissions and flags the one that must carry a sync packet.
module trdb_resync_counter #(
    parameter int RESYNC_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    upd_i,        // emission of a qualified instruction
    input  logic                    first_i,      // that emission starts a qualified run
    input  logic [RESYNC_CNT_W-1:0] resync_max_i, // 0 disables resync
    output logic                    resync_o,     // combinational, valid with upd_i
    output logic [RESYNC_CNT_W-1:0] cnt_o
);

    localparam logic [RESYNC_CNT_W-1:0] CNT_ONE = {{(RESYNC_CNT_W-1){1'b0}}, 1'b1};

    logic [RESYNC_CNT_W-1:0] cnt;
    logic                    hit;

    // Resync point: period reached, not disabled, and never on a start packet.
    always_comb begin
        hit      = (resync_max_i != '0) && (cnt == (resync_max_i - CNT_ONE));
        resync_o = upd_i && !first_i && hit;
    end

    // Counter restarts at 1 on a run start, clears on resync, otherwise saturates upward.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (upd_i) begin
            if (first_i)
                cnt <= CNT_ONE;
            else if (hit)
                cnt <= '0;
            else if (!(&cnt))
                cnt <= cnt + CNT_ONE;
        end
    end

    assign cnt_o = cnt;

endmodule

// File: rtl/trdb_qual_tracker.sv
// Delays retired instructions by one so each can be tagged with start/stop/sync
// flags using the qualification of the instruction that follows it.
module trdb_qual_tracker
    import trdb_pkg::*;
#(
    parameter int XLEN         = TRDB_XLEN,
    parameter int RESYNC_CNT_W = TRDB_RESYNC_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    inst_valid_i,
    input  logic [XLEN-1:0]         iaddr_i,
    input  logic                    trace_qualified_i,
    input  logic                    flush_i,
    input  logic [RESYNC_CNT_W-1:0] resync_max_i,
    output logic                    out_valid_o,
    output logic [XLEN-1:0]         out_iaddr_o,
    output logic                    out_qualified_o,
    output logic                    first_qualified_o,
    output logic                    last_qualified_o,
    output logic                    resync_o
);

    trdb_stage_state_e       st;
    trdb_trace_state_e       tr_st;
    trdb_stage_t             stage;
    logic                    flush_pend;

    logic                    emit;
    logic                    look_q;
    logic                    first_c;
    logic                    last_c;
    logic                    resync_c;
    logic [RESYNC_CNT_W-1:0] cnt_unused;

    // Emission happens when a staged instruction is pushed out by a new one
    // (lookahead = new qual) or drained by a flush (lookahead = unqualified).
    always_comb begin
        emit   = 1'b0;
        look_q = 1'b0;
        if (st == ST_STAGED) begin
            if (inst_valid_i) begin
                emit   = 1'b1;
                look_q = trace_qualified_i;
            end else if (flush_i || flush_pend) begin
                emit   = 1'b1;
            end
        end
    end

    // Flags for the instruction leaving the stage this cycle.
    always_comb begin
        first_c = emit && stage.qual && (tr_st == TR_OFF);
        last_c  = emit && stage.qual && !look_q;
    end

    trdb_resync_counter #(
        .RESYNC_CNT_W (RESYNC_CNT_W)
    ) u_resync (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .upd_i        (emit && stage.qual),
        .first_i      (first_c),
        .resync_max_i (resync_max_i),
        .resync_o     (resync_c),
        .cnt_o        (cnt_unused)
    );

    // Staging FSM: one-deep holding register plus deferred-flush bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st         <= ST_EMPTY;
            stage      <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (st)
                ST_EMPTY: begin
                    if (inst_valid_i) begin
                        stage      <= trdb_stage_t'{iaddr: iaddr_i, qual: trace_qualified_i};
                        st         <= ST_STAGED;
                        flush_pend <= flush_i;
                    end
                end
                ST_STAGED: begin
                    if (inst_valid_i) begin
                        stage <= trdb_stage_t'{iaddr: iaddr_i, qual: trace_qualified_i};
                        if (flush_i)
                            flush_pend <= 1'b1;
                    end else if (flush_i || flush_pend) begin
                        st         <= ST_EMPTY;
                        flush_pend <= 1'b0;
                    end
                end
                default: begin
                    st         <= ST_EMPTY;
                    flush_pend <= 1'b0;
                end
            endcase
        end
    end

    // Trace-state FSM: ON only while a qualified run is still open after the emission.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tr_st <= TR_OFF;
        else if (emit)
            tr_st <= trdb_next_trace(stage.qual, look_q);
    end

    // Output registers: everything is zero outside an emission cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o       <= 1'b0;
            out_iaddr_o       <= '0;
            out_qualified_o   <= 1'b0;
            first_qualified_o <= 1'b0;
            last_qualified_o  <= 1'b0;
            resync_o          <= 1'b0;
        end else begin
            out_valid_o       <= emit;
            out_iaddr_o       <= emit ? stage.iaddr : '0;
            out_qualified_o   <= emit && stage.qual;
            first_qualified_o <= first_c;
            last_qualified_o  <= last_c;
            resync_o          <= resync_c;
        end
    end

endmodule

// File: tb/tb_trdb_qual_tracker.sv
// Directed and random bench for trdb_qual_tracker against a queue-based model.
module tb_trdb_qual_tracker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_valid_i;
    logic [31:0] iaddr_i;
    logic        trace_qualified_i;
    logic        flush_i;
    logic [15:0] resync_max_i;
    logic        out_valid_o;
    logic [31:0] out_iaddr_o;
    logic        out_qualified_o;
    logic        first_qualified_o;
    logic        last_qualified_o;
    logic        resync_o;

    trdb_qual_tracker dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .inst_valid_i      (inst_valid_i),
        .iaddr_i           (iaddr_i),
        .trace_qualified_i (trace_qualified_i),
        .flush_i           (flush_i),
        .resync_max_i      (resync_max_i),
        .out_valid_o       (out_valid_o),
        .out_iaddr_o       (out_iaddr_o),
        .out_qualified_o   (out_qualified_o),
        .first_qualified_o (first_qualified_o),
        .last_qualified_o  (last_qualified_o),
        .resync_o          (resync_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: a list of pending instructions and the run bookkeeping.
    typedef struct {
        logic [31:0] a;
        bit          q;
    } ins_t;

    ins_t        pend_q[$];
    bit          in_run;
    int          cnt;
    bit          pend_flush;
    int          rmax;
    bit          e_v, e_q, e_first, e_last, e_res;
    logic [31:0] e_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {27'b0, out_valid_o, out_iaddr_o, out_qualified_o,
                first_qualified_o, last_qualified_o, resync_o};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {27'b0, e_v, e_a, e_q, e_first, e_last, e_res};
    endfunction

    task automatic m_reset();
        pend_q.delete();
        in_run = 0; cnt = 0; pend_flush = 0;
        e_v = 0; e_a = '0; e_q = 0; e_first = 0; e_last = 0; e_res = 0;
    endtask

    // Apply the flag rules to instruction s with next-instruction qualification lq.
    task automatic m_emit(input ins_t s, input bit lq);
        e_v = 1; e_a = s.a; e_q = s.q;
        e_first = s.q && !in_run;
        e_last  = s.q && !lq;
        e_res   = 0;
        if (s.q) begin
            if (e_first) cnt = 1;
            else if (rmax != 0 && cnt == rmax - 1) begin e_res = 1; cnt = 0; end
            else if (cnt < 65535) cnt++;
        end
        in_run = s.q && lq;
    endtask

    task automatic m_clock(input bit v, input logic [31:0] a, input bit q, input bit f);
        ins_t n;
        e_v = 0; e_a = '0; e_q = 0; e_first = 0; e_last = 0; e_res = 0;
        if (v) begin
            if (pend_q.size() != 0) m_emit(pend_q.pop_front(), q);
            n.a = a; n.q = q;
            pend_q.push_back(n);
            if (f) pend_flush = 1;
        end else if (pend_q.size() != 0 && (f || pend_flush)) begin
            m_emit(pend_q.pop_front(), 0);
            pend_flush = 0;
        end
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic step(input bit v, input logic [31:0] a, input bit q, input bit f, input string tag);
        inst_valid_i = v; iaddr_i = a; trace_qualified_i = q; flush_i = f;
        resync_max_i = 16'(rmax);
        @(posedge clk_i);
        m_clock(v, a, q, f);
        @(negedge clk_i);
        chk(tag, dut_vec(), exp_vec());
    endtask

    initial begin
        rst_i = 1; inst_valid_i = 0; iaddr_i = '0; trace_qualified_i = 0;
        flush_i = 0; rmax = 0; resync_max_i = '0;
        m_reset();
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", dut_vec(), 64'd0);
        rst_i = 0;

        // 1: A,B qualified then C unqualified
        step(1, 32'h1000, 1, 0, "t1_A_in");
        chk("t1_A_held", {63'd0, out_valid_o}, 64'd0);
        step(1, 32'h1004, 1, 0, "t1_B_in");
        chk("t1_A_out", {27'd0, out_valid_o, out_iaddr_o, first_qualified_o, last_qualified_o, 1'b0},
            {27'd0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0});
        step(1, 32'h1008, 0, 0, "t1_C_in");
        chk("t1_B_out", {27'd0, out_valid_o, out_iaddr_o, first_qualified_o, last_qualified_o, 1'b0},
            {27'd0, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0});
        step(0, 32'h0, 0, 1, "t1_drain");

        // 2: lone qualified instruction between unqualified ones
        step(1, 32'h2000, 0, 0, "t2_x");
        step(1, 32'h2004, 1, 0, "t2_y");
        step(1, 32'h2008, 0, 0, "t2_z");
        chk("t2_first_last", {59'd0, out_valid_o, out_iaddr_o == 32'h2004, first_qualified_o, last_qualified_o, 1'b0},
            {59'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        step(0, 32'h0, 0, 1, "t2_drain");

        // 3: flush drains a lone staged qualified instruction
        step(1, 32'h3000, 1, 0, "t3_A");
        step(0, 32'h0, 0, 1, "t3_flush");
        chk("t3_last", {62'd0, out_valid_o, last_qualified_o}, {62'd0, 1'b1, 1'b1});
        step(0, 32'h0, 0, 1, "t3_flush_empty");
        chk("t3_nothing", {63'd0, out_valid_o}, 64'd0);

        // 4: flush together with valid defers the drain
        step(1, 32'h4000, 1, 0, "t4_A");
        step(1, 32'h4004, 1, 1, "t4_B_flush");
        chk("t4_A_out", {31'd0, out_valid_o, out_iaddr_o}, {31'd0, 1'b1, 32'h4000});
        step(0, 32'h0, 0, 0, "t4_idle_drain");
        chk("t4_B_out", {30'd0, out_valid_o, out_iaddr_o, last_qualified_o}, {30'd0, 1'b1, 32'h4004, 1'b1});

        // 5: resync every 4 qualified emissions, then disabled
        rmax = 4;
        for (int i = 0; i <= 10; i++) begin
            step(1, 32'h5000 + 32'(i * 4), 1, 0, "t5_step");
            if (i >= 1)
                chk($sformatf("t5_resync_%0d", i), {62'd0, out_valid_o, resync_o},
                    {62'd0, 1'b1, ((i % 4) == 0) ? 1'b1 : 1'b0});
        end
        step(0, 32'h0, 0, 1, "t5_drain");
        rmax = 0;
        for (int i = 0; i <= 10; i++) begin
            step(1, 32'h5800 + 32'(i * 4), 1, 0, "t5_off_step");
            if (i >= 1) chk("t5_off_resync", {63'd0, resync_o}, 64'd0);
        end
        step(0, 32'h0, 0, 1, "t5_off_drain");

        // 6: asynchronous reset while staged and emitting
        step(1, 32'h6000, 1, 0, "t6_A");
        step(1, 32'h6004, 1, 0, "t6_B");
        rst_i = 1;
        #1;
        m_reset();
        chk("t6_reset_immediate", dut_vec(), 64'd0);
        @(negedge clk_i);
        rst_i = 0;
        step(1, 32'h6100, 1, 0, "t6_C_in");
        chk("t6_no_emit", {63'd0, out_valid_o}, 64'd0);
        step(1, 32'h6104, 0, 0, "t6_D_in");
        chk("t6_first", {61'd0, out_valid_o, out_iaddr_o == 32'h6100, first_qualified_o},
            {61'd0, 1'b1, 1'b1, 1'b1});

        // Random traffic with occasional resync period changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0: rmax = 0;
                    1: rmax = 1;
                    2: rmax = 2;
                    3: rmax = 3;
                    default: rmax = 5;
                endcase
            end
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
